// File: rtl/mac_lanes.sv
// Multi-lane unsigned x signed multiply-accumulate with a 2-stage valid/ready pipeline.
// Optional round-half-up on the output path: define MAC_LANES_ROUND_EN.
module mac_lanes #(
  parameter int LANES     = 4,
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 16,
  parameter int ACC_GUARD = 4,
  parameter int OUT_SCALE = 16,
  parameter int OUT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         arst_n_in,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_first,
  input  logic                         in_last,
  input  logic [LANES*A_WIDTH-1:0]     a_in,
  input  logic [LANES*B_WIDTH-1:0]     b_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*OUT_WIDTH-1:0]   out_data,
  output logic [LANES-1:0]             out_sat
);

  localparam int PROD_WIDTH = A_WIDTH + B_WIDTH;
  localparam int ACC_WIDTH  = PROD_WIDTH + ACC_GUARD;
  // One spare bit so the rounding constant can never overflow the sum.
  localparam int SUM_WIDTH  = ACC_WIDTH + 1;

  typedef logic signed [PROD_WIDTH-1:0] prod_t;
  typedef logic signed [ACC_WIDTH-1:0]  acc_t;
  typedef logic signed [SUM_WIDTH-1:0]  sum_t;

  localparam sum_t OUT_MAX = (SUM_WIDTH'(1) <<< (OUT_WIDTH - 1)) - SUM_WIDTH'(1);
  localparam sum_t OUT_MIN = ~OUT_MAX;
`ifdef MAC_LANES_ROUND_EN
  localparam sum_t RND = (SUM_WIDTH'(1) << OUT_SCALE) >> 1;
`else
  localparam sum_t RND = '0;
`endif

  logic  s1_en, s2_en;
  logic  s1_valid, s1_first, s1_last;
  prod_t prod     [LANES];
  prod_t s1_prod  [LANES];
  acc_t  acc      [LANES];
  acc_t  acc_next [LANES];
  logic [LANES*OUT_WIDTH-1:0] data_next;
  logic [LANES-1:0]           sat_next;

  assign s2_en    = !out_valid || out_ready;
  assign s1_en    = !s1_valid || s2_en;
  assign in_ready = s1_en;

  // Zero-extend a and sign-extend b to the full product width; the exact
  // product always fits in A_WIDTH+B_WIDTH signed bits.
  always_comb begin
    logic [PROD_WIDTH-1:0] a_ext, b_ext;
    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    a_ext = '0;
    b_ext = '0;
    for (int i = 0; i < LANES; i++) begin
      a_ext   = {{B_WIDTH{1'b0}}, a_in[i*A_WIDTH +: A_WIDTH]};
      b_ext   = {{A_WIDTH{b_in[i*B_WIDTH + B_WIDTH - 1]}}, b_in[i*B_WIDTH +: B_WIDTH]};
      prod[i] = $signed(a_ext) * $signed(b_ext);
    end
  end

  // Accumulate, then scale / round / clip on the output path only.
  always_comb begin
    sum_t sum, shifted;
    sum       = '0;
    shifted   = '0;
    data_next = '0;
    sat_next  = '0;
    for (int i = 0; i < LANES; i++) begin
      acc_next[i] = s1_first ? acc_t'(s1_prod[i]) : acc[i] + acc_t'(s1_prod[i]);
      sum         = SUM_WIDTH'(acc_next[i]) + RND;
      shifted     = sum >>> OUT_SCALE;
      if (shifted > OUT_MAX) begin
        data_next[i*OUT_WIDTH +: OUT_WIDTH] = OUT_MAX[OUT_WIDTH-1:0];
        sat_next[i] = 1'b1;
      end else if (shifted < OUT_MIN) begin
        data_next[i*OUT_WIDTH +: OUT_WIDTH] = OUT_MIN[OUT_WIDTH-1:0];
        sat_next[i] = 1'b1;
      end else begin
        data_next[i*OUT_WIDTH +: OUT_WIDTH] = shifted[OUT_WIDTH-1:0];
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      s1_valid  <= 1'b0;
      s1_first  <= 1'b0;
      s1_last   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= '0;
      // NOTE: the accumulator array is reset because a headless frame accumulates onto it.
      for (int i = 0; i < LANES; i++) begin
        s1_prod[i] <= '0;
        acc[i]     <= '0;
      end
    end else begin
      if (s1_en) begin
        s1_valid <= in_valid;
        s1_first <= in_first;
        s1_last  <= in_last;
        s1_prod  <= prod;
      end
      if (s2_en) begin
        if (s1_valid) begin
          acc <= acc_next;
          if (s1_last) begin
            out_data  <= data_next;
            out_sat   <= sat_next;
            out_valid <= 1'b1;
          end else begin
            out_valid <= 1'b0;
          end
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_lanes.sv
// Directed bench for mac_lanes: a frame-level arithmetic model plus literal checks.
module tb_mac_lanes;

  localparam int LANES = 4;
  localparam int AW    = 16;
  localparam int BW    = 16;
  localparam int GUARD = 4;
  localparam int SCALE = 16;
  localparam int OW    = 16;
  localparam int ACCW  = AW + BW + GUARD;

  logic        clk = 1'b0;
  logic        arst_n_in = 1'b0;
  logic        in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0;
  logic        in_ready;
  logic [63:0] a_in = '0, b_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_data;
  logic [3:0]  out_sat;

  mac_lanes #(
    .LANES(LANES), .A_WIDTH(AW), .B_WIDTH(BW), .ACC_GUARD(GUARD),
    .OUT_SCALE(SCALE), .OUT_WIDTH(OW)
  ) dut (
    .clk(clk), .arst_n_in(arst_n_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first), .in_last(in_last),
    .a_in(a_in), .b_in(b_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [63:0] data;
    logic [3:0]  sat;
  } res_t;

  res_t        expq[$];
  longint      acc_m [LANES];
  int          n_out = 0;
  logic        stall_prev = 1'b0;
  logic [63:0] held_data;
  logic [3:0]  held_sat;

  function automatic longint wrap_acc(input longint v);
    return (v <<< (64 - ACCW)) >>> (64 - ACCW);
  endfunction

  function automatic void lane_result(input longint acc, output logic [15:0] d, output logic s);
    longint v;
    v = acc;
`ifdef MAC_LANES_ROUND_EN
    v = v + (longint'(1) <<< (SCALE - 1));
`endif
    v = v >>> SCALE;
    s = 1'b1;
    if (v > 32767)       d = 16'h7FFF;
    else if (v < -32768) d = 16'h8000;
    else begin
      d = v[15:0];
      s = 1'b0;
    end
  endfunction

  always @(negedge clk) begin
    longint      p, a_v, b_v;
    logic [15:0] d;
    logic        s;
    res_t        r;
    if (!arst_n_in) begin
      expq.delete();
      for (int i = 0; i < LANES; i++) acc_m[i] = 0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", {63'd0, out_valid}, 64'd1);
        check("hold_data", out_data, held_data);
        check("hold_sat", {60'd0, out_sat}, {60'd0, held_sat});
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          check("unexpected_out", {63'd0, out_valid}, 64'd0);
        end else begin
          r = expq.pop_front();
          check("out_data", out_data, r.data);
          check("out_sat", {60'd0, out_sat}, {60'd0, r.sat});
          n_out++;
        end
      end
      stall_prev = out_valid && !out_ready;
      held_data  = out_data;
      held_sat   = out_sat;
      if (in_valid && in_ready) begin
        r.data = '0;
        r.sat  = '0;
        for (int i = 0; i < LANES; i++) begin
          a_v      = longint'({48'd0, a_in[i*AW +: AW]});
          b_v      = longint'($signed(b_in[i*BW +: BW]));
          p        = a_v * b_v;
          acc_m[i] = wrap_acc(in_first ? p : acc_m[i] + p);
          lane_result(acc_m[i], d, s);
          r.data[i*OW +: OW] = d;
          r.sat[i]           = s;
        end
        if (in_last) expq.push_back(r);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [63:0] lanes4(input logic [15:0] x);
    return {x, x, x, x};
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the beat is accepted.
  task automatic send(input bit f, input bit l, input logic [63:0] a, input logic [63:0] b);
    int k;
    in_valid = 1'b1;
    in_first = f;
    in_last  = l;
    a_in     = a;
    b_in     = b;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (k == 200) check("accept_timeout", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out(output int cycles);
    cycles = 0;
    while (cycles < 100) begin
      @(negedge clk);
      cycles++;
      if (out_valid) break;
    end
    if (!out_valid) check("out_timeout", {63'd0, out_valid}, 64'd1);
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (expq.size() == 0 && !out_valid) break;
    end
    check("drain_empty", 64'(expq.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    #3;
    arst_n_in = 1'b0;
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_out_sat", {60'd0, out_sat}, 64'd0);
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    arst_n_in = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    int  cyc;
    int  n0;
    bit  done;
    logic [15:0] rnd_exp;

    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_out_data", out_data, 64'd0);
    check("reset_out_sat", {60'd0, out_sat}, 64'd0);
    arst_n_in = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset", {63'd0, in_ready}, 64'd1);

    // Single multiply with latency check.
    send(1, 1, {16'h0, 16'h0, 16'h0003, 16'h8000}, {16'h0, 16'h0, 16'h0005, 16'hFFFE});
    wait_out(cyc);
    check("single_latency", 64'(cyc), 64'd2);
    check("single_lane0", {48'd0, out_data[15:0]}, 64'hFFFF);
    check("single_sat", {60'd0, out_sat}, 64'd0);
    drain();

    // Four-beat frame, no output before the last beat.
    send(1, 0, lanes4(16'h4000), lanes4(16'h4000));
    send(0, 0, lanes4(16'h4000), lanes4(16'h4000));
    send(0, 0, lanes4(16'h4000), lanes4(16'h4000));
    check("frame_no_early_out", {63'd0, out_valid}, 64'd0);
    send(0, 1, lanes4(16'h4000), lanes4(16'h4000));
    wait_out(cyc);
    check("frame4_data", out_data, lanes4(16'h4000));
    check("frame4_sat", {60'd0, out_sat}, 64'd0);
    drain();

    // Positive and negative saturation.
    send(1, 0, lanes4(16'hFFFF), lanes4(16'h7FFF));
    repeat (2) send(0, 0, lanes4(16'hFFFF), lanes4(16'h7FFF));
    send(0, 1, lanes4(16'hFFFF), lanes4(16'h7FFF));
    wait_out(cyc);
    check("sat_pos_data", out_data, lanes4(16'h7FFF));
    check("sat_pos_flag", {60'd0, out_sat}, 64'hF);
    drain();
    send(1, 0, lanes4(16'hFFFF), lanes4(16'h8000));
    repeat (2) send(0, 0, lanes4(16'hFFFF), lanes4(16'h8000));
    send(0, 1, lanes4(16'hFFFF), lanes4(16'h8000));
    wait_out(cyc);
    check("sat_neg_data", out_data, lanes4(16'h8000));
    check("sat_neg_flag", {60'd0, out_sat}, 64'hF);
    drain();

    // Rounding versus truncation of -0.5 LSB.
`ifdef MAC_LANES_ROUND_EN
    rnd_exp = 16'h0000;
`else
    rnd_exp = 16'hFFFF;
`endif
    send(1, 1, lanes4(16'h0001), lanes4(16'h8000));
    wait_out(cyc);
    check("round_half", out_data, lanes4(rnd_exp));
    drain();

    // Abandoned frame, then a headless beat accumulating onto the held value.
    send(1, 0, lanes4(16'h7000), lanes4(16'h7000));
    send(1, 1, lanes4(16'h0100), lanes4(16'h0300));
    wait_out(cyc);
    check("abandon_restart", out_data, lanes4(16'h0003));
    drain();
    send(0, 1, lanes4(16'h0100), lanes4(16'h0100));
    wait_out(cyc);
    check("headless_accum", out_data, lanes4(16'h0004));
    drain();

    // Stall: S1 fills one beat behind the held output, then in_ready drops.
    out_ready = 1'b0;
    send(1, 1, {16'h1, 16'h2, 16'h3, 16'h4}, lanes4(16'h7FFF));
    send(1, 1, lanes4(16'h2000), {16'hFFF0, 16'h0010, 16'h8000, 16'h1234});
    @(negedge clk);
    check("stall_out_valid", {63'd0, out_valid}, 64'd1);
    check("stall_in_ready", {63'd0, in_ready}, 64'd0);
    repeat (3) begin
      @(negedge clk);
      check("stall_in_ready_held", {63'd0, in_ready}, 64'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    // Ten single-beat frames under random backpressure.
    n0   = n_out;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++)
          send(1, 1, lanes4(16'(16'h1357 * (i + 1))), lanes4(16'(16'h0F0F * (i + 3))));
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();
    check("stream_count", 64'(n_out - n0), 64'd10);

    // Reset in the middle of a frame.
    send(1, 0, lanes4(16'h1111), lanes4(16'h2222));
    in_valid = 1'b1;
    in_first = 1'b0;
    in_last  = 1'b1;
    a_in     = lanes4(16'h3333);
    b_in     = lanes4(16'h4444);
    @(posedge clk);
    pulse_reset();

    // Reset while an output is stalled, then a fresh frame.
    out_ready = 1'b0;
    send(1, 1, lanes4(16'h1234), lanes4(16'h0100));
    wait_out(cyc);
    pulse_reset();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_rereset", {63'd0, in_ready}, 64'd1);
    send(1, 1, {48'd0, 16'h0002}, {48'd0, 16'h8000});
    wait_out(cyc);
    check("post_reset_lane0", {48'd0, out_data[15:0]}, 64'hFFFF);
    check("post_reset_sat", {60'd0, out_sat}, 64'd0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac_lanes.md
Name: mac_lanes

Overview:
Parametrised multi-lane multiply-accumulate unit, successor to the single combinational fixed-point multiplier. Each lane multiplies an unsigned operand by a signed operand. Lanes accumulate products over a frame of beats delimited by first/last flags, then scale, optionally round and saturate the sum. The unit is a 2-stage elastic pipeline with valid/ready on both sides. It sits between the feature-map/weight fetch path and the output writeback buffer of the accelerator datapath.

Parameters:
LANES, 4, number of parallel independent lanes
A_WIDTH, 16, unsigned operand width per lane
B_WIDTH, 16, signed operand width per lane
ACC_GUARD, 4, extra accumulator bits; ACC_WIDTH = A_WIDTH+B_WIDTH+ACC_GUARD
OUT_SCALE, 16, arithmetic right shift applied to accumulator before narrowing (0 to ACC_WIDTH-1)
OUT_WIDTH, 16, signed output width per lane (must be <= ACC_WIDTH-OUT_SCALE)

Ports:
clk  input  1  clock, rising edge
arst_n_in  input  1  asynchronous active-low reset
in_valid  input  1  input beat valid
in_ready  output  1  input beat accepted when in_valid && in_ready
in_first  input  1  beat starts a new frame (restarts accumulation)
in_last  input  1  beat ends frame (produces one output)
a_in  input  LANES*A_WIDTH  unsigned operands, lane i at [i*A_WIDTH +: A_WIDTH]
b_in  input  LANES*B_WIDTH  signed operands, lane i at [i*B_WIDTH +: B_WIDTH]
out_valid  output  1  output result valid
out_ready  input  1  result consumed when out_valid && out_ready
out_data  output  LANES*OUT_WIDTH  signed results, lane i at [i*OUT_WIDTH +: OUT_WIDTH]
out_sat  output  LANES  per-lane flag: result was clipped

Behaviour:
- Interface: one clock, clk; reset arst_n_in is asynchronous and active-low. Reset clears all registers: s1_valid=0, out_valid=0, out_data=0, out_sat=0, accumulators=0. in_ready is 1 one cycle after reset release.
- S1 registers per-lane products, first/last flags and s1_valid. Product = zero-extended a × sign-extended b, exact in A_WIDTH+B_WIDTH signed bits.
- S2 holds per-lane accumulators (ACC_WIDTH, two's complement, wrap on overflow, no internal saturation), plus out_data, out_sat and out_valid.
- Enables: s2_en = !out_valid || out_ready; s1_en = !s1_valid || s2_en; in_ready = s1_en (combinational from the state and out_ready only, never from in_valid).
- On s1_en: S1 loads the input beat; s1_valid <= in_valid && in_ready.
- On s2_en with s1_valid:
  - acc <= first ? prod : acc + prod (sign-extended).
  - If last: out_data <= sat(next_acc >>> OUT_SCALE), out_sat set per lane on clipping, out_valid <= 1.
  - If not last: out_valid <= 0.
- On s2_en without s1_valid: out_valid <= 0. Accumulators are held.
- Latency: an accepted last beat gives out_valid 2 cycles later when there is no backpressure. Throughput is 1 beat/cycle.
- Saturation clips to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- While out_valid && !out_ready: out_data and out_sat are stable. The pipeline fills S1 (1 beat) and then drops in_ready.
- A beat with first && last is a single plain multiply.
- A first beat before the previous frame's last discards the partial sum (no output for the abandoned frame).
- A beat with neither flag before any first accumulates onto the held value (accumulator is 0 after reset).
- Reset mid-frame or mid-stall discards all in-flight data. No output is produced.
- Lanes are fully independent arithmetically and share the handshake.

Optional Feature:
MAC_LANES_ROUND_EN. When defined, 2^(OUT_SCALE-1) is added to the accumulator before the shift (round half up). No-op when OUT_SCALE=0. Undefined: truncation toward -inf. The accumulator contents are unaffected either way; rounding applies only on the output path.

Test Plan:
- Single beat, first=last=1, lane0 a=0x8000, b=0xFFFE -> out lane0 0xFFFF (-1), out_sat=0, out_valid exactly 2 cycles after acceptance.
- 4-beat frame, all lanes a=0x4000, b=0x4000 -> one output, each lane 0x4000. out_valid is not asserted on beats 1-3.
- Saturation: 4-beat frame, a=0xFFFF, b=0x7FFF -> 0x7FFF, out_sat=1. With b=0x8000 -> 0x8000, out_sat=1.
- Rounding: a=0x0001, b=0x8000, single beat -> 0xFFFF without MAC_LANES_ROUND_EN, 0x0000 with it.
- Backpressure: stream 10 single-beat frames with out_ready toggling at random -> all 10 results in order, none lost or duplicated. out_data is stable while stalled, and in_ready drops after S1 fills.
- Reset: assert arst_n_in mid-frame and during an out_valid stall -> outputs 0 immediately. After release, a new first=last beat with a=2, b=0x8000 gives 0xFFFF with no partial-sum carryover.
